// File: rtl/haz_detect_unit.sv
// Hazard detection front-end: shadows EX/MEM, times the memory port and tracks one
// outstanding branch with a 2-bit predictor, producing registered hazard flags.
module haz_detect_unit #(
    parameter int unsigned REG_W    = 4,
    parameter int unsigned MEM_LAT  = 3,
    parameter logic [1:0]  CTR_INIT = 2'b01
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    input  logic [REG_W-1:0] issue_rs1,
    input  logic [REG_W-1:0] issue_rs2,
    input  logic [REG_W-1:0] issue_rd,
    input  logic             issue_is_load,
    input  logic             issue_uses_mem,
    input  logic             issue_is_branch,
    input  logic             br_resolve_valid,
    input  logic             br_taken,
    input  logic             stall_in,
    input  logic             flush_in,
    output logic             data_o,
    output logic             fwrd_o,
    output logic             str_o,
    output logic             ctrl_o,
    output logic             branch_o,
    output logic             crct_o,
    output logic             pred_taken_o
);

    localparam logic [2:0] BUSY_LOAD = 3'(MEM_LAT);

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) return (ctr == 2'b11) ? ctr : ctr + 2'b01;
        else       return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

    // Shadow pipeline: only EX and MEM feed hazard checks, WB is assumed written before read.
    logic             ex_vld_q, ex_vld_d, mem_vld_q;
    logic [REG_W-1:0] ex_rd_q, ex_rd_d, mem_rd_q;
    logic             ex_ld_q, ex_ld_d;
    logic [2:0]       busy_q, busy_d;
    logic             pend_q, pend_d, pred_lat_q, pred_lat_d;
    logic [1:0]       ctr_q, ctr_d;
    logic             data_q, data_d, fwrd_q, fwrd_d, str_q, str_d;
    logic             branch_q, branch_d, crct_q, crct_d;

    logic acc, resolve, match_ex, match_mem;

    always_comb begin
        acc       = issue_valid & ~stall_in & ~flush_in;
        resolve   = br_resolve_valid & pend_q;
        match_ex  = ex_vld_q & (ex_rd_q != '0) &
                    ((ex_rd_q == issue_rs1) | (ex_rd_q == issue_rs2));
        match_mem = mem_vld_q & (mem_rd_q != '0) &
                    ((mem_rd_q == issue_rs1) | (mem_rd_q == issue_rs2));

        ex_vld_d = acc;
        ex_rd_d  = issue_rd;
        ex_ld_d  = issue_is_load;

        if (acc & issue_uses_mem) busy_d = BUSY_LOAD;
        else if (busy_q != 3'd0)  busy_d = busy_q - 3'd1;
        else                      busy_d = 3'd0;

        // A same-cycle resolve and new acceptance leaves the new branch pending.
        pend_d     = pend_q;
        pred_lat_d = pred_lat_q;
        if (resolve) pend_d = 1'b0;
        if (acc & issue_is_branch) begin
            pend_d     = 1'b1;
            pred_lat_d = ctr_q[1];
        end
        ctr_d = resolve ? ctr_next(ctr_q, br_taken) : ctr_q;

        data_d   = issue_valid & (match_ex | match_mem);
        fwrd_d   = data_d & ~(match_ex & ex_ld_q);
        str_d    = issue_valid & ((issue_uses_mem & (busy_q != 3'd0)) |
                                  (issue_is_branch & pend_q & ~br_resolve_valid));
        branch_d = resolve;
        crct_d   = resolve ? (pred_lat_q == br_taken) : 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_vld_q   <= 1'b0;
            mem_vld_q  <= 1'b0;
            busy_q     <= 3'd0;
            pend_q     <= 1'b0;
            pred_lat_q <= 1'b0;
            ctr_q      <= CTR_INIT;
            data_q     <= 1'b0;
            fwrd_q     <= 1'b0;
            str_q      <= 1'b0;
            branch_q   <= 1'b0;
            crct_q     <= 1'b1;
        end else begin
            ex_vld_q   <= ex_vld_d;
            mem_vld_q  <= ex_vld_q;
            busy_q     <= busy_d;
            pend_q     <= pend_d;
            pred_lat_q <= pred_lat_d;
            ctr_q      <= ctr_d;
            data_q     <= data_d;
            fwrd_q     <= fwrd_d;
            str_q      <= str_d;
            branch_q   <= branch_d;
            crct_q     <= crct_d;
        end
    end

    // Register indices and load tag are only meaningful alongside their valid bit.
    always_ff @(posedge clk) begin
        ex_rd_q  <= ex_rd_d;
        ex_ld_q  <= ex_ld_d;
        mem_rd_q <= ex_rd_q;
    end

    assign data_o       = data_q;
    assign fwrd_o       = fwrd_q;
    assign str_o        = str_q;
    assign ctrl_o       = pend_q;
    assign branch_o     = branch_q;
    assign crct_o       = crct_q;
    assign pred_taken_o = ctr_q[1];

endmodule

// File: tb/tb_haz_detect_unit.sv
// Scoreboard bench for haz_detect_unit: a rule-level model predicts the flags for every
// cycle, and a separate monitor compares them against the DUT outputs.
module tb_haz_detect_unit;

    localparam int         REG_W    = 4;
    localparam int         MEM_LAT  = 3;
    localparam logic [1:0] CTR_INIT = 2'b01;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             issue_valid = 1'b0;
    logic [REG_W-1:0] issue_rs1 = '0, issue_rs2 = '0, issue_rd = '0;
    logic             issue_is_load = 1'b0, issue_uses_mem = 1'b0, issue_is_branch = 1'b0;
    logic             br_resolve_valid = 1'b0, br_taken = 1'b0;
    logic             stall_in = 1'b0, flush_in = 1'b0;
    logic             data_o, fwrd_o, str_o, ctrl_o, branch_o, crct_o, pred_taken_o;

    haz_detect_unit #(.REG_W(REG_W), .MEM_LAT(MEM_LAT), .CTR_INIT(CTR_INIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd(issue_rd), .issue_is_load(issue_is_load), .issue_uses_mem(issue_uses_mem),
        .issue_is_branch(issue_is_branch), .br_resolve_valid(br_resolve_valid),
        .br_taken(br_taken), .stall_in(stall_in), .flush_in(flush_in),
        .data_o(data_o), .fwrd_o(fwrd_o), .str_o(str_o), .ctrl_o(ctrl_o),
        .branch_o(branch_o), .crct_o(crct_o), .pred_taken_o(pred_taken_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct { int due; logic [6:0] v; } exp_t;
    typedef struct { bit v; int rd; bit ld; } slot_t;

    exp_t  q[$];
    slot_t pipe[$];
    int    cnt, free_cyc;
    bit    pend, plat;
    int    n_vec = 0, n_err = 0;

    function automatic bit raw(slot_t s, int a, int b);
        return s.v && s.rd != 0 && (s.rd == a || s.rd == b);
    endfunction

    function automatic void model_reset();
        slot_t bub;
        bub = '{v: 1'b0, rd: 0, ld: 1'b0};
        pipe.delete();
        pipe.push_back(bub);
        pipe.push_back(bub);
        cnt = int'(CTR_INIT);
        pend = 1'b0;
        plat = 1'b0;
        free_cyc = 0;
    endfunction

    function automatic void push_rst(int due);
        exp_t e;
        e.due = due;
        e.v   = {5'b00000, 1'b1, CTR_INIT[1]};
        q.push_back(e);
    endfunction

    task automatic step(input bit iv, input int rs1, input int rs2, input int rd,
                        input bit ld, input bit mem, input bit br, input bit brv,
                        input bit tk, input bit st, input bit fl);
        bit acc, rex, rmem, d, f, s, res, c, old_msb, busy;
        slot_t ns;
        exp_t  e;
        issue_valid = iv; issue_rs1 = REG_W'(rs1); issue_rs2 = REG_W'(rs2);
        issue_rd = REG_W'(rd); issue_is_load = ld; issue_uses_mem = mem;
        issue_is_branch = br; br_resolve_valid = brv; br_taken = tk;
        stall_in = st; flush_in = fl;

        acc  = iv && !st && !fl;
        rex  = raw(pipe[0], rs1, rs2);
        rmem = raw(pipe[1], rs1, rs2);
        d    = iv && (rex || rmem);
        f    = d && !(rex && pipe[0].ld);
        busy = cyc < free_cyc;
        s    = iv && ((mem && busy) || (br && pend && !brv));
        res  = brv && pend;
        c    = res ? (plat == tk) : 1'b1;

        old_msb = cnt >= 2;
        if (res) begin
            cnt  = tk ? ((cnt == 3) ? 3 : cnt + 1) : ((cnt == 0) ? 0 : cnt - 1);
            pend = 1'b0;
        end
        if (acc && br) begin
            pend = 1'b1;
            plat = old_msb;
        end
        if (acc && mem) free_cyc = cyc + MEM_LAT + 1;
        ns = '{v: acc, rd: rd, ld: ld};
        pipe.push_front(ns);
        void'(pipe.pop_back());

        e.due = cyc + 1;
        e.v   = {d, f, s, pend, res, c, bit'(cnt >= 2)};
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        while (q.size() > 0 && q[$].due >= cyc) void'(q.pop_back());
        push_rst(cyc);
        repeat (n) begin
            @(posedge clk); #1;
            push_rst(cyc);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            logic [6:0] got;
            e   = q.pop_front();
            got = {data_o, fwrd_o, str_o, ctrl_o, branch_o, crct_o, pred_taken_o};
            n_vec++;
            if (got !== e.v || e.due != cyc) begin
                n_err++;
                $display("FAIL flags cyc=%0d due=%0d {data,fwrd,str,ctrl,branch,crct,pred} got=%b expected=%b",
                         cyc, e.due, got, e.v);
            end
        end
    end

    initial begin
        model_reset();
        @(posedge clk); #1;
        do_reset(2);

        // Forwardable RAW, then zero-register source against rd=0
        step(1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0);
        step(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(); idle();

        // Load-use with a one-cycle stall
        step(1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0);
        step(1, 0, 5, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(); idle(); idle(); idle();

        // Structural: port busy for MEM_LAT cycles
        step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        repeat (4) step(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        idle();

        // Branch mispredict, then correct prediction
        do_reset(1);
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        idle();
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        idle();
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        idle();

        // Branch while pending, resolve together with a new branch, stray resolve
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle();

        for (int i = 0; i < 1500; i++) begin
            if (i == 500 || i == 1000) do_reset(2);
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
        end

        repeat (3) @(posedge clk);
        #2;
        if (q.size() != 0 || n_vec < 12) begin
            n_vec++;
            n_err++;
            $display("FAIL drain pending=%0d checked=%0d required pending=0 checked>=12",
                     q.size(), n_vec);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
